strobe_edge_detector: RTL and testbench

- Front-end conditioning stage that sits directly upstream of the pulse extender.
- Takes an asynchronous external strobe (host chip-select / ROM read strobe) and synchronizes it into clk.
- Glitch-filters it, then emits a clean single-cycle pulse on the selected edge(s); pulse_out drives the extender's signal input.
- Rate-limits pulses with a holdoff window and keeps an event counter for debug readout.

---
 rtl/strobe_edge_pkg.sv | 29 ++
 rtl/strobe_edge_detector_sync_chain.sv | 31 +++
 rtl/strobe_edge_detector.sv | 187 ++++++++++++++++++
 tb/tb_strobe_edge_detector.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/strobe_edge_pkg.sv
// Shared types and constants for the strobe edge detector.
package strobe_edge_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        QUAL_HIGH   = 2'b01,
        STABLE_HIGH = 2'b10,
        QUAL_LOW    = 2'b11
    } edge_state_e;

    localparam logic [1:0] EDGE_NONE = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILTER_LEN  = 4;
    localparam int DEF_HOLDOFF     = 8;
    localparam int DEF_CNT_W       = 8;

    // Filter counter is sized for the widest legal FILTER_LEN.
    localparam int FILT_W = 8;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int width_for(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/strobe_edge_detector_sync_chain.sv
// Purpose: reset-cleared multi-flop synchronizer for one asynchronous bit.
// Latency: STAGES clk edges. Backpressure: none, samples every cycle.
module sync_chain
    import strobe_edge_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/strobe_edge_detector.sv
// Purpose: sync + glitch-filter a strobe, emit rate-limited edge pulses; STROBE_EDGE_DETECTOR_OVERFLOW_EN saturates the counter.
// Latency: SYNC_STAGES + FILTER_LEN edges from first sampling edge to level_out/pulse_out.
// Backpressure: none; edges qualified during holdoff update level_out only and are dropped.
module strobe_edge_detector
    import strobe_edge_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILTER_LEN  = DEF_FILTER_LEN,
    parameter int HOLDOFF     = DEF_HOLDOFF,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             async_in,
    input  logic [1:0]       edge_sel,
    input  logic             count_clr,
    output logic             pulse_out,
    output logic             level_out,
    output logic [CNT_W-1:0] event_count
`ifdef STROBE_EDGE_DETECTOR_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int                HOLD_W    = width_for(HOLDOFF);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic              sync_q;
    edge_state_e       state_q,  state_d;
    logic [FILT_W-1:0] filt_q,   filt_d;
    logic [HOLD_W-1:0] hold_q,   hold_d;
    logic              pulse_q,  pulse_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              flip_rise;
    logic              flip_fall;
    logic              rise_en;
    logic              fall_en;
    logic              fire;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (async_in),
        .q       (sync_q)
    );

    // Qualification FSM: a new level must persist FILTER_LEN synchronized cycles.
    always_comb begin
        state_d   = state_q;
        filt_d    = filt_q;
        flip_rise = 1'b0;
        flip_fall = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                if (sync_q) begin
                    if (FILTER_LEN == 1) begin
                        state_d   = STABLE_HIGH;
                        flip_rise = 1'b1;
                    end else begin
                        state_d = QUAL_HIGH;
                        filt_d  = FILT_W'(1);
                    end
                end
            end
            QUAL_HIGH: begin
                if (!sync_q) begin
                    state_d = STABLE_LOW;
                    filt_d  = '0;
                end else if (filt_q + FILT_W'(1) == FILT_LAST) begin
                    state_d   = STABLE_HIGH;
                    filt_d    = '0;
                    flip_rise = 1'b1;
                end else begin
                    filt_d = filt_q + FILT_W'(1);
                end
            end
            STABLE_HIGH: begin
                if (!sync_q) begin
                    if (FILTER_LEN == 1) begin
                        state_d   = STABLE_LOW;
                        flip_fall = 1'b1;
                    end else begin
                        state_d = QUAL_LOW;
                        filt_d  = FILT_W'(1);
                    end
                end
            end
            QUAL_LOW: begin
                if (sync_q) begin
                    state_d = STABLE_HIGH;
                    filt_d  = '0;
                end else if (filt_q + FILT_W'(1) == FILT_LAST) begin
                    state_d   = STABLE_LOW;
                    filt_d    = '0;
                    flip_fall = 1'b1;
                end else begin
                    filt_d = filt_q + FILT_W'(1);
                end
            end
            default: begin
                state_d = STABLE_LOW;
                filt_d  = '0;
            end
        endcase
    end

    // edge_sel only matters in the cycle a flip happens.
    always_comb begin
        rise_en = (edge_sel == EDGE_RISE) || (edge_sel == EDGE_BOTH);
        fall_en = (edge_sel == EDGE_FALL) || (edge_sel == EDGE_BOTH);
        fire    = (hold_q == '0) &&
                  ((flip_rise && rise_en) || (flip_fall && fall_en));
        pulse_d = fire;
        hold_d  = hold_q;
        if (fire) begin
            hold_d = HOLD_LOAD;
        end else if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
        end
    end

`ifdef STROBE_EDGE_DETECTOR_OVERFLOW_EN
    logic ovf_q, ovf_d;

    // Saturating count; overflow latches on the first pulse lost at the ceiling.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (count_clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (fire) begin
            if (count_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    // Clear wins over a coincident pulse; the pulse itself is still emitted.
    always_comb begin
        count_d = count_q;
        if (count_clr) begin
            count_d = '0;
        end else if (fire) begin
            count_d = count_q + CNT_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STABLE_LOW;
            filt_q  <= '0;
            hold_q  <= '0;
            pulse_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            hold_q  <= hold_d;
            pulse_q <= pulse_d;
            count_q <= count_d;
        end
    end

    assign pulse_out   = pulse_q;
    assign level_out   = (state_q == STABLE_HIGH) || (state_q == QUAL_LOW);
    assign event_count = count_q;

endmodule

// File: tb/tb_strobe_edge_detector.sv
// Scoreboard bench for strobe_edge_detector at default parameters.
module tb_strobe_edge_detector;

    localparam int LAT  = 6;
    localparam int HOLD = 8;

    typedef struct {
        int         cyc;
        logic       lvl;
        logic [7:0] cnt;
    } pexp_t;

    typedef struct {
        int   cyc;
        logic lvl;
    } lexp_t;

    logic       clk;
    logic       reset_n;
    logic       async_in;
    logic [1:0] edge_sel;
    logic       count_clr;
    logic       pulse_out;
    logic       level_out;
    logic [7:0] event_count;
`ifdef STROBE_EDGE_DETECTOR_OVERFLOW_EN
    logic       overflow;
    logic       ovf_m;
`endif

    int         cyc;
    int         n_chk;
    int         n_bad;
    pexp_t      pq[$];
    lexp_t      lq[$];
    logic [7:0] exp_cnt;
    logic       lvl_m;
    int         last_pulse;

    strobe_edge_detector dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .async_in    (async_in),
        .edge_sel    (edge_sel),
        .count_clr   (count_clr),
        .pulse_out   (pulse_out),
        .level_out   (level_out),
        .event_count (event_count)
`ifdef STROBE_EDGE_DETECTOR_OVERFLOW_EN
        ,
        .overflow    (overflow)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic bump_count();
`ifdef STROBE_EDGE_DETECTOR_OVERFLOW_EN
        if (exp_cnt == 8'hFF) ovf_m = 1'b1;
        else exp_cnt = exp_cnt + 8'd1;
`else
        exp_cnt = exp_cnt + 8'd1;
`endif
    endtask

    // Drive a clean level at a negedge, predict the flip and any pulse, then wait n cycles.
    task automatic drive(input logic v, input int n);
        int    flip;
        lexp_t le;
        pexp_t pe;
        async_in = v;
        flip = cyc + LAT;
        if (v != lvl_m) begin
            le.cyc = flip;
            le.lvl = v;
            lq.push_back(le);
            if (((v && edge_sel[0]) || (!v && edge_sel[1])) && (flip - last_pulse > HOLD)) begin
                bump_count();
                pe.cyc = flip;
                pe.lvl = v;
                pe.cnt = exp_cnt;
                pq.push_back(pe);
                last_pulse = flip;
            end
            lvl_m = v;
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_pulse"}, pulse_out, 0);
        check({tag, "_level"}, level_out, 0);
        check({tag, "_count"}, event_count, 0);
    endtask

    always @(negedge clk) begin
        if (pq.size() > 0 && pq[0].cyc == cyc) begin
            check("pulse_present", pulse_out, 1);
            check("pulse_level", level_out, pq[0].lvl);
            check("pulse_count", event_count, pq[0].cnt);
            void'(pq.pop_front());
        end else if (pulse_out) begin
            check("spurious_pulse", pulse_out, 0);
        end
        if (lq.size() > 0 && lq[0].cyc == cyc) begin
            check("level_flip", level_out, lq[0].lvl);
            void'(lq.pop_front());
        end
    end

    initial begin
        pexp_t pe;
        n_chk      = 0;
        n_bad      = 0;
        exp_cnt    = 8'd0;
        lvl_m      = 1'b0;
        last_pulse = -1000;
`ifdef STROBE_EDGE_DETECTOR_OVERFLOW_EN
        ovf_m      = 1'b0;
`endif
        reset_n    = 1'b0;
        async_in   = 1'b0;
        edge_sel   = 2'b01;
        count_clr  = 1'b0;

        // Outputs stay cleared while reset is held with a toggling input.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            async_in = ~async_in;
            check_cleared("in_reset");
        end
        @(negedge clk);
        async_in = 1'b0;
        reset_n  = 1'b1;
        repeat (10) @(negedge clk);

        // Clean step: level and one pulse after 6 edges, count 1.
        drive(1'b1, 20);
        drive(1'b0, 20);

        // A 3-cycle excursion is rejected; a 4-cycle one qualifies.
        async_in = 1'b1;
        repeat (3) @(negedge clk);
        async_in = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_level", level_out, 0);
        check("glitch_count", event_count, 1);
        drive(1'b1, 4);
        drive(1'b0, 20);

        // Holdoff boundary: rise 8 edges after a pulse is dropped, 9 edges is allowed.
        drive(1'b1, 4);
        drive(1'b0, 4);
        drive(1'b1, 4);
        drive(1'b0, 20);
        drive(1'b1, 4);
        drive(1'b0, 5);
        drive(1'b1, 4);
        drive(1'b0, 20);

        // Both edges, toggling every 5 cycles: falls land inside holdoff.
        edge_sel = 2'b11;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5);
            drive(1'b0, 5);
        end
        repeat (20) @(negedge clk);

        // Falling-only, then no edges at all.
        edge_sel = 2'b10;
        drive(1'b1, 12);
        drive(1'b0, 20);
        edge_sel = 2'b00;
        drive(1'b1, 12);
        drive(1'b0, 20);

        // Clear, then 256 spaced pulses.
        edge_sel  = 2'b01;
        count_clr = 1'b1;
        exp_cnt   = 8'd0;
`ifdef STROBE_EDGE_DETECTOR_OVERFLOW_EN
        ovf_m     = 1'b0;
`endif
        @(negedge clk);
        count_clr = 1'b0;
        check("clr_idle", event_count, 0);
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 5);
            drive(1'b0, 5);
        end
        repeat (15) @(negedge clk);
`ifdef STROBE_EDGE_DETECTOR_OVERFLOW_EN
        check("sat_count", event_count, 255);
        check("sat_overflow", overflow, ovf_m);
        check("sat_overflow_set", overflow, 1);
`else
        check("wrap_count", event_count, 0);
`endif

        // count_clr in the same cycle as a pulse: pulse fires, count reads 0.
        drive(1'b1, 5);
        pe = pq[$];
        void'(pq.pop_back());
        pe.cnt = 8'd0;
        pq.push_back(pe);
        exp_cnt = 8'd0;
`ifdef STROBE_EDGE_DETECTOR_OVERFLOW_EN
        ovf_m = 1'b0;
`endif
        count_clr = 1'b1;
        @(negedge clk);
        count_clr = 1'b0;
        repeat (14) @(negedge clk);
        check("clr_pulse_count", event_count, 0);
`ifdef STROBE_EDGE_DETECTOR_OVERFLOW_EN
        check("clr_overflow", overflow, 0);
`endif
        drive(1'b0, 20);

        // Reset in the middle of qualification with the input held high.
        async_in = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_cleared("mid_reset");
            @(negedge clk);
        end
        reset_n    = 1'b1;
        exp_cnt    = 8'd0;
        lvl_m      = 1'b0;
        last_pulse = -1000;
`ifdef STROBE_EDGE_DETECTOR_OVERFLOW_EN
        ovf_m      = 1'b0;
`endif
        drive(1'b1, 20);
        check("post_reset_level", level_out, 1);
        check("post_reset_count", event_count, 1);
        drive(1'b0, 20);

        check("pulses_outstanding", pq.size(), 0);
        check("levels_outstanding", lq.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
